// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU slice (funct codes, default width).
// Optional feature macro used by this slice: ALU_OVERFLOW_EN.
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [5:0] FUNCT_ADD = 6'd27;
    localparam logic [5:0] FUNCT_SUB = 6'd28;
    localparam logic [5:0] FUNCT_AND = 6'd29;
    localparam logic [5:0] FUNCT_OR  = 6'd30;
    localparam logic [5:0] FUNCT_SRL = 6'd31;
    localparam logic [5:0] FUNCT_SLL = 6'd32;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational logical shift left/right with the last
// shifted-out bit. A guard bit is appended on the side bits leave from, so a
// single shift yields both the result and the carry; shamt=0 gives carry 0.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] src,
    input  logic [4:0]       shamt,
    input  logic             shift_left,
    output logic [WIDTH-1:0] shifted,
    output logic             shift_carry
);

    logic [WIDTH:0] srl_ext_s;
    logic [WIDTH:0] sll_ext_s;

    // Guard-bit extended shifts in both directions
    always_comb begin
        srl_ext_s = {src, 1'b0} >> shamt;
        sll_ext_s = {1'b0, src} << shamt;
    end

    // Select the requested direction and its shifted-out bit
    always_comb begin
        shifted     = {WIDTH{1'b0}};
        shift_carry = 1'b0;
        if (shift_left) begin
            shifted     = sll_ext_s[WIDTH-1:0];
            shift_carry = sll_ext_s[WIDTH];
        end else begin
            shifted     = srl_ext_s[WIDTH:1];
            shift_carry = srl_ext_s[0];
        end
    end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: registered 32-bit ALU (add/sub/and/or/srl/sll) with zero and
// carry flags, one-cycle latency, one operation per cycle.
// Optional: define ALU_OVERFLOW_EN to add the signed-overflow output.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] Src1,
    input  logic [WIDTH-1:0] Src2,
    input  logic [5:0]       funct,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] shift_res_s;
    logic             shift_carry_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             carry_r;

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .src         (Src1),
        .shamt       (shamt),
        .shift_left  (funct == FUNCT_SLL),
        .shifted     (shift_res_s),
        .shift_carry (shift_carry_s)
    );

    // Extended add/subtract: top bit is carry-out resp. borrow
    always_comb begin
        add_s = {1'b0, Src1} + {1'b0, Src2};
        sub_s = {1'b0, Src1} - {1'b0, Src2};
    end

    // Operation select; unknown funct codes produce result 0, carry 0
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        case (funct)
            FUNCT_ADD: begin
                res_s   = add_s[WIDTH-1:0];
                carry_s = add_s[WIDTH];
            end
            FUNCT_SUB: begin
                res_s   = sub_s[WIDTH-1:0];
                carry_s = sub_s[WIDTH];
            end
            FUNCT_AND: begin
                res_s   = Src1 & Src2;
                carry_s = 1'b0;
            end
            FUNCT_OR: begin
                res_s   = Src1 | Src2;
                carry_s = 1'b0;
            end
            FUNCT_SRL, FUNCT_SLL: begin
                res_s   = shift_res_s;
                carry_s = shift_carry_s;
            end
            default: begin
                res_s   = {WIDTH{1'b0}};
                carry_s = 1'b0;
            end
        endcase
    end

    // Output registers: capture on in_valid, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                result_r <= res_s;
                zero_r   <= (res_s == {WIDTH{1'b0}});
                carry_r  <= carry_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign carry     = carry_r;

`ifdef ALU_OVERFLOW_EN
    logic ovf_s;
    logic overflow_r;

    // Two's-complement overflow for ADD/SUB, 0 for all other operations
    always_comb begin
        ovf_s = 1'b0;
        if (funct == FUNCT_ADD) begin
            ovf_s = (Src1[WIDTH-1] == Src2[WIDTH-1]) &&
                    (add_s[WIDTH-1] != Src1[WIDTH-1]);
        end else if (funct == FUNCT_SUB) begin
            ovf_s = (Src1[WIDTH-1] != Src2[WIDTH-1]) &&
                    (sub_s[WIDTH-1] != Src1[WIDTH-1]);
        end else begin
            ovf_s = 1'b0;
        end
    end

    // Overflow register, captured alongside the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (in_valid) begin
            overflow_r <= ovf_s;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign overflow = overflow_r;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench for alu_unit with hand-computed results.
module tb_alu_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        carry;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int vectors;
    int miscompares;

    alu_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .Src1      (src1),
        .Src2      (src2),
        .funct     (funct),
        .shamt     (shamt),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .carry     (carry)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic exp_valid,
                         input logic [31:0] exp_res, input logic exp_zero,
                         input logic exp_carry);
        vectors++;
        assert ({out_valid, result, zero, carry} === {exp_valid, exp_res, exp_zero, exp_carry})
        else begin
            miscompares++;
            $error("FAIL %s: got v=%0b r=%h z=%0b c=%0b, expected v=%0b r=%h z=%0b c=%0b",
                   tag, out_valid, result, zero, carry,
                   exp_valid, exp_res, exp_zero, exp_carry);
        end
    endtask

`ifdef ALU_OVERFLOW_EN
    task automatic check_ovf(input string tag, input logic exp_ovf);
        vectors++;
        assert (overflow === exp_ovf)
        else begin
            miscompares++;
            $error("FAIL %s: got overflow=%0b, expected %0b", tag, overflow, exp_ovf);
        end
    endtask
`endif

    // Drive one operation at the falling edge, check one cycle after capture
    task automatic op(input string tag, input logic [5:0] f,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [31:0] exp_res,
                      input logic exp_zero, input logic exp_carry);
        @(negedge clk);
        in_valid = 1'b1;
        funct    = f;
        src1     = a;
        src2     = b;
        shamt    = sh;
        @(posedge clk);
        #1;
        check(tag, 1'b1, exp_res, exp_zero, exp_carry);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        src1     = 32'd0;
        src2     = 32'd0;
        funct    = 6'd0;
        shamt    = 5'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0, 32'd0, 1'b0, 1'b0);
`ifdef ALU_OVERFLOW_EN
        check_ovf("reset_ovf", 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Basic operations, back to back
        op("add_7_6", 6'd27, 32'd7, 32'd6, 5'd0, 32'd13, 1'b0, 1'b0);
        op("sub_7_6", 6'd28, 32'd7, 32'd6, 5'd0, 32'd1,  1'b0, 1'b0);
        op("and_7_6", 6'd29, 32'd7, 32'd6, 5'd0, 32'd6,  1'b0, 1'b0);
        op("or_7_6",  6'd30, 32'd7, 32'd6, 5'd0, 32'd7,  1'b0, 1'b0);
        op("srl_7_3", 6'd31, 32'd7, 32'd0, 5'd3, 32'd0,  1'b1, 1'b1);
        op("sll_7_3", 6'd32, 32'd7, 32'd0, 5'd3, 32'd56, 1'b0, 1'b0);

        // Carry and borrow
        op("add_carry",  6'd27, 32'hFFFF_FFFF, 32'd3, 5'd0, 32'd2,         1'b0, 1'b1);
        op("sub_borrow", 6'd28, 32'd3,         32'd4, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        op("sll_carry",  6'd32, 32'hFFFF_FFFF, 32'd0, 5'd2, 32'hFFFF_FFFC, 1'b0, 1'b1);
        op("srl_carry",  6'd31, 32'h8000_0001, 32'd0, 5'd1, 32'h4000_0000, 1'b0, 1'b1);
        op("sll_31",     6'd32, 32'h0000_0003, 32'd0, 5'd31, 32'h8000_0000, 1'b0, 1'b1);
        op("srl_31",     6'd31, 32'h4000_0000, 32'd0, 5'd31, 32'h0000_0000, 1'b1, 1'b1);
        op("sub_equal",  6'd28, 32'd5,         32'd5, 5'd0, 32'd0,         1'b1, 1'b0);

        // Edge cases
        op("sll_sh0", 6'd32, 32'h1234_5678, 32'd0, 5'd0, 32'h1234_5678, 1'b0, 1'b0);
        op("srl_sh0", 6'd31, 32'h8765_4321, 32'd0, 5'd0, 32'h8765_4321, 1'b0, 1'b0);
        op("funct_0",  6'd0,  32'd7, 32'd6, 5'd3, 32'd0, 1'b1, 1'b0);
        op("funct_33", 6'd33, 32'hFFFF_FFFF, 32'd1, 5'd1, 32'd0, 1'b1, 1'b0);

        // Signed overflow cases (result/carry apply in both builds)
        op("add_ovf", 6'd27, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 1'b0);
`ifdef ALU_OVERFLOW_EN
        check_ovf("add_ovf_flag", 1'b1);
`endif
        op("sub_ovf", 6'd28, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b0);
`ifdef ALU_OVERFLOW_EN
        check_ovf("sub_ovf_flag", 1'b1);
`endif
        op("and_no_ovf", 6'd29, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0, 1'b0, 1'b0);
`ifdef ALU_OVERFLOW_EN
        check_ovf("and_ovf_flag", 1'b0);
`endif

        // in_valid low: out_valid drops, outputs hold previous values
        @(negedge clk);
        in_valid = 1'b0;
        funct    = 6'd27;
        src1     = 32'd100;
        src2     = 32'd200;
        @(posedge clk);
        #1;
        check("idle_hold", 1'b0, 32'h00F0_00F0, 1'b0, 1'b0);

        // Asynchronous reset between edges clears immediately
        op("pre_reset", 6'd30, 32'h0000_0F00, 32'h0000_00F0, 5'd0, 32'h0000_0FF0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 1'b0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        // Reset while an operation is pending discards it
        @(negedge clk);
        in_valid = 1'b1;
        funct    = 6'd27;
        src1     = 32'd7;
        src2     = 32'd6;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("reset_discard", 1'b0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_discard_idle", 1'b0, 32'd0, 1'b0, 1'b0);

        // Resume normally after reset
        op("resume_add", 6'd27, 32'd40, 32'd2, 5'd0, 32'd42, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("resume_idle", 1'b0, 32'd42, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
